// File: rtl/intra_filter_pkg.sv
// intra_filter_pkg: shared widths, rounding constants and pixel clip helper for the intra interpolation filter
package intra_filter_pkg;
    localparam int PROD_W     = 16;
    localparam int NUM_PROD   = 16;
    localparam int SEL_W      = 4;
    localparam int OUT_W      = 8;
    localparam int ACC_W      = 18;
    localparam int ROUND_OFS  = 32;
    localparam int FILT_SHIFT = 6;

    typedef logic [OUT_W-1:0] pixel_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Floor shift, then saturate: sign bit means negative, any bit above OUT_W means > 255
    function automatic pixel_t clip_pixel(input acc_t s);
        acc_t r;
        r = s >>> FILT_SHIFT;
        return r[ACC_W-1] ? '0 : (|r[ACC_W-2:OUT_W]) ? '1 : r[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/tap_select_sign.sv
// tap_select_sign: picks one of the tap's constant products and applies the coefficient sign
module tap_select_sign
    import intra_filter_pkg::*;
(
    input  logic [NUM_PROD*PROD_W-1:0] prod,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       neg,
    output acc_t                       term
);
    logic [NUM_PROD-1:0][PROD_W-1:0] prods;
    acc_t mag;
    assign prods = prod;
    assign mag   = acc_t'(prods[sel]);
    assign term  = neg ? -mag : mag;
endmodule

// File: rtl/filter_accum_4tap.sv
// filter_accum_4tap: 3-stage select/sum/clip pipeline producing one predicted pixel per accepted beat
module filter_accum_4tap
    import intra_filter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PROD*PROD_W-1:0] prod_t0,
    input  logic [NUM_PROD*PROD_W-1:0] prod_t1,
    input  logic [NUM_PROD*PROD_W-1:0] prod_t2,
    input  logic [NUM_PROD*PROD_W-1:0] prod_t3,
    input  logic [SEL_W-1:0]           sel_t0,
    input  logic [SEL_W-1:0]           sel_t1,
    input  logic [SEL_W-1:0]           sel_t2,
    input  logic [SEL_W-1:0]           sel_t3,
    input  logic [3:0]                 neg_t,
    output logic                       out_valid,
    input  logic                       out_ready,
    output pixel_t                     out_pixel
);
    logic [NUM_PROD*PROD_W-1:0] prod [4];
    logic [SEL_W-1:0] sel [4];
    acc_t term [4];
    acc_t t1 [4];
    acc_t s2;
    logic v1, v2, v3, stall;

    assign prod = '{prod_t0, prod_t1, prod_t2, prod_t3};
    assign sel  = '{sel_t0, sel_t1, sel_t2, sel_t3};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_tap
            tap_select_sign u_tap (
                .prod (prod[i]),
                .sel  (sel[i]),
                .neg  (neg_t[i]),
                .term (term[i])
            );
        end
    endgenerate

    // Empty slots stall too, so the whole pipe freezes on any downstream backpressure
    assign stall     = v3 && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v3;

    always_ff @(posedge clk) begin
        if (!stall) begin
            t1 <= term;
            s2 <= t1[0] + t1[1] + t1[2] + t1[3] + acc_t'(ROUND_OFS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_pixel <= '0;
        end else if (!stall) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_pixel <= clip_pixel(s2);
        end
    end
endmodule

// File: tb/tb_filter_accum_4tap.sv
// tb_filter_accum_4tap: table vectors, corner sequences and a randomized scoreboard run against an arithmetic model
module tb_filter_accum_4tap;
    import intra_filter_pkg::*;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [NUM_PROD*PROD_W-1:0] prod_t0, prod_t1, prod_t2, prod_t3;
    logic [SEL_W-1:0] sel_t0, sel_t1, sel_t2, sel_t3;
    logic [3:0] neg_t;
    pixel_t out_pixel;

    logic [3:0][15:0] cur_pv;
    logic [3:0] cur_nv;
    int q[$];
    int total = 0;
    int passed = 0;

    typedef struct {
        logic [3:0][15:0] pv;
        logic [15:0]      sv;
        logic [3:0]       nv;
        int               exp;
    } vec_t;
    vec_t vecs [10];

    filter_accum_4tap dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod_t0   (prod_t0),
        .prod_t1   (prod_t1),
        .prod_t2   (prod_t2),
        .prod_t3   (prod_t3),
        .sel_t0    (sel_t0),
        .sel_t1    (sel_t1),
        .sel_t2    (sel_t2),
        .sel_t3    (sel_t3),
        .neg_t     (neg_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel)
    );

    always #5 clk = ~clk;

    // Plain integer arithmetic: signed sum, floor division by 64, saturate to 0..255
    function automatic int model(input logic [3:0][15:0] pv, input logic [3:0] nv);
        int s, r;
        s = 32;
        for (int t = 0; t < 4; t++) s += nv[t] ? -int'(pv[t]) : int'(pv[t]);
        r = (s >= 0) ? s / 64 : -((-s + 63) / 64);
        return (r < 0) ? 0 : (r > 255) ? 255 : r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0][15:0] pv, input logic [15:0] sv, input logic [3:0] nv, input logic v);
        logic [NUM_PROD*PROD_W-1:0] pk [4];
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NUM_PROD; k++) pk[t][k*PROD_W +: PROD_W] = PROD_W'($urandom_range(0, 15810));
            pk[t][sv[t*4 +: 4]*PROD_W +: PROD_W] = pv[t];
        end
        prod_t0 = pk[0]; prod_t1 = pk[1]; prod_t2 = pk[2]; prod_t3 = pk[3];
        sel_t0 = sv[3:0]; sel_t1 = sv[7:4]; sel_t2 = sv[11:8]; sel_t3 = sv[15:12];
        neg_t = nv;
        in_valid = v;
        cur_pv = pv;
        cur_nv = nv;
    endtask

    task automatic drive_rand(input logic v);
        logic [3:0][15:0] pv;
        for (int t = 0; t < 4; t++) pv[t] = 16'($urandom_range(0, 15810));
        drive(pv, 16'($urandom), 4'($urandom), v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        drive(v.pv, v.sv, v.nv, 1'b1);
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick;
            lat++;
        end
        chk($sformatf("vec%0d latency", idx), lat, 3);
        chk($sformatf("vec%0d pixel", idx), int'(out_pixel), v.exp);
        tick;
    endtask

    // Scoreboard: inputs and handshakes are stable between the falling edge and the next rising edge
    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected output", 1, 0);
                else chk("scoreboard pixel", int'(out_pixel), q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(cur_pv, cur_nv));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][15:0] bp;
        int held, seen, lat;
        vecs[0] = '{pv: {16'd0, 16'd3200, 16'd3200, 16'd0},             sv: 16'h0440, nv: 4'b0000, exp: 100};
        vecs[1] = '{pv: {16'd15810, 16'd15810, 16'd15810, 16'd15810},   sv: 16'h0000, nv: 4'b0000, exp: 255};
        vecs[2] = '{pv: {16'd15810, 16'd0, 16'd0, 16'd15810},           sv: 16'h5A3C, nv: 4'b1001, exp: 0};
        vecs[3] = '{pv: {16'd0, 16'd0, 16'd0, 16'd31},                  sv: 16'hF37A, nv: 4'b0000, exp: 0};
        vecs[4] = '{pv: {16'd0, 16'd0, 16'd32, 16'd0},                  sv: 16'h1234, nv: 4'b0000, exp: 1};
        vecs[5] = '{pv: {16'd0, 16'd0, 16'd0, 16'd33},                  sv: 16'h8888, nv: 4'b0001, exp: 0};
        vecs[6] = '{pv: {16'd100, 16'd500, 16'd2000, 16'd10000},        sv: 16'hC0DE, nv: 4'b1010, exp: 131};
        vecs[7] = '{pv: {16'd1288, 16'd15000, 16'd0, 16'd0},            sv: 16'h9F01, nv: 4'b0000, exp: 255};
        vecs[8] = '{pv: {16'd1256, 16'd15000, 16'd0, 16'd0},            sv: 16'h2B6E, nv: 4'b0000, exp: 254};
        vecs[9] = '{pv: {16'd0, 16'd0, 16'd0, 16'd6400},                sv: 16'h000F, nv: 4'b0000, exp: 100};

        rst_n = 1'b0;
        out_ready = 1'b0;
        drive_rand(1'b1);
        tick; tick; tick;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_pixel", int'(out_pixel), 0);
        chk("reset in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: six beats with distinct results 10, 30, ..., 110
        for (int k = 0; k < 3; k++) begin
            bp = '0;
            bp[1] = 16'(64 * (10 + 20 * k) - 32);
            drive(bp, 16'($urandom), 4'b0000, 1'b1);
            tick;
        end
        chk("bp first out_valid", int'(out_valid), 1);
        bp = '0;
        bp[1] = 16'(64 * 70 - 32);
        drive(bp, 16'($urandom), 4'b0000, 1'b1);
        out_ready = 1'b0;
        #1;
        chk("bp in_ready falls", int'(in_ready), 0);
        held = int'(out_pixel);
        chk("bp held pixel", held, 10);
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("bp stall out_valid", int'(out_valid), 1);
            chk("bp stall pixel", int'(out_pixel), 10);
            chk("bp stall in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick;
        for (int k = 4; k < 6; k++) begin
            bp = '0;
            bp[1] = 16'(64 * (10 + 20 * k) - 32);
            drive(bp, 16'($urandom), 4'b0000, 1'b1);
            tick;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() > 0; c++) tick;
        chk("bp drained", q.size(), 0);
        tick; tick;

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            drive_rand(1'b1);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_pixel", int'(out_pixel), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            seen += int'(out_valid);
        end
        chk("midrst no stale beats", seen, 0);
        run_vec(vecs[6], 6);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 300; n++) begin
            drive_rand($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 9) < 7;
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        lat = 0;
        while (q.size() > 0 && lat < 20) begin
            tick;
            lat++;
        end
        chk("random drained", q.size(), 0);
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
